// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the two-read-port register file
// and its stack-pointer overflow monitor.
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRIPPED = 2'd2
    } ovf_state_t;

endpackage

// File: rtl/sp_ovf_monitor.sv
// Sticky stack-pointer overflow monitor: flags SP writes that fall below
// the configured limit, once the SP slot has been initialised.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | SP never written since reset; next SP write is the init
// ARMED   | SP initialised; writes below spLimit trip the flag
// TRIPPED | violation seen; ovf=1 until ovfClr without a new violation
module sp_ovf_monitor
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             spWrEn,
    input  logic [WIDTH-1:0] wData,
    input  logic [WIDTH-1:0] spLimit,
    input  logic             ovfClr,
    output logic             ovf
);

    ovf_state_t state;
    ovf_state_t state_next;
    logic       violation;

    // Equality with the limit is legal.
    assign violation = spWrEn && (wData < spLimit);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ovf        = 1'b0;
        case (state)
            IDLE: begin
                if (spWrEn) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (violation) begin
                    state_next = TRIPPED;
                end
            end
            TRIPPED: begin
                ovf = 1'b1;
                if (ovfClr && !violation) begin
                    state_next = ARMED;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/reg_file_2r.sv
// Register file with two combinational read ports, one write port and a
// stack-pointer slot watched by sp_ovf_monitor. Define REG_FILE_BYPASS_EN
// to forward same-cycle write data to matching read ports.
module reg_file_2r
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int SP_IDX = DEPTH - 1
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [$clog2(DEPTH)-1:0] i_rAddr1,
    output logic [WIDTH-1:0]         o_rData1,
    input  logic [$clog2(DEPTH)-1:0] i_rAddr2,
    output logic [WIDTH-1:0]         o_rData2,
    input  logic [WIDTH-1:0]         i_wData,
    input  logic [$clog2(DEPTH)-1:0] i_wAddr,
    input  logic                     i_wEn,
    input  logic [WIDTH-1:0]         i_spLimit,
    input  logic                     i_ovfClr,
    output logic [WIDTH-1:0]         o_reportSP,
    output logic                     o_spOvf
);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [DEPTH-1:0] wr_sel;

    assign wr_sel = {{(DEPTH-1){1'b0}}, i_wEn} << i_wAddr;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                slots[g] <= '0;
            end else if (wr_sel[g]) begin
                slots[g] <= i_wData;
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    assign o_rData1 = (i_wEn && (i_rAddr1 == i_wAddr)) ? i_wData : slots[i_rAddr1];
    assign o_rData2 = (i_wEn && (i_rAddr2 == i_wAddr)) ? i_wData : slots[i_rAddr2];
`else
    assign o_rData1 = slots[i_rAddr1];
    assign o_rData2 = slots[i_rAddr2];
`endif

    // Always the stored value, even when bypass is enabled.
    assign o_reportSP = slots[SP_IDX];

    sp_ovf_monitor #(
        .WIDTH(WIDTH)
    ) u_sp_ovf_monitor (
        .clk     (i_clk),
        .rstn    (i_rstn),
        .spWrEn  (wr_sel[SP_IDX]),
        .wData   (i_wData),
        .spLimit (i_spLimit),
        .ovfClr  (i_ovfClr),
        .ovf     (o_spOvf)
    );

endmodule

// File: tb/tb_reg_file_2r.sv
// Self-checking bench for reg_file_2r: directed scenarios plus randomized
// traffic against a behavioural model. Honours REG_FILE_BYPASS_EN.
module tb_reg_file_2r;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int SP_IDX = DEPTH - 1;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             rstn;
    logic [2:0]       rAddr1;
    logic [2:0]       rAddr2;
    logic [2:0]       wAddr;
    logic [WIDTH-1:0] wData;
    logic             wEn;
    logic [WIDTH-1:0] spLimit;
    logic             ovfClr;
    logic [WIDTH-1:0] rData1;
    logic [WIDTH-1:0] rData2;
    logic [WIDTH-1:0] reportSP;
    logic             spOvf;

    int checks = 0;
    int errors = 0;

    // Reference model: plain memory plus "SP initialised" and sticky flag.
    logic [WIDTH-1:0] mem [DEPTH];
    bit               sp_init;
    bit               flag;

    reg_file_2r #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SP_IDX(SP_IDX)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_rAddr1  (rAddr1),
        .o_rData1  (rData1),
        .i_rAddr2  (rAddr2),
        .o_rData2  (rData2),
        .i_wData   (wData),
        .i_wAddr   (wAddr),
        .i_wEn     (wEn),
        .i_spLimit (spLimit),
        .i_ovfClr  (ovfClr),
        .o_reportSP(reportSP),
        .o_spOvf   (spOvf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_read(input logic [2:0] ra);
        if (BYPASS && wEn && (ra == wAddr)) return wData;
        return mem[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        sp_init = 1'b0;
        flag    = 1'b0;
    endtask

    task automatic model_edge();
        bit sp_wr;
        sp_wr = wEn && (wAddr == SP_IDX);
        if (sp_wr && !sp_init) begin
            sp_init = 1'b1;
        end else if (sp_init) begin
            if (sp_wr && (wData < spLimit)) flag = 1'b1;
            else if (ovfClr)                flag = 1'b0;
        end
        if (wEn) mem[wAddr] = wData;
    endtask

    // One clock cycle: drive, check reads before the edge, clock, check after.
    task automatic step(input logic [2:0] ra1, input logic [2:0] ra2, input logic we,
                        input logic [2:0] wa, input logic [WIDTH-1:0] wd,
                        input logic [WIDTH-1:0] lim, input logic clr);
        rAddr1  = ra1;
        rAddr2  = ra2;
        wEn     = we;
        wAddr   = wa;
        wData   = wd;
        spLimit = lim;
        ovfClr  = clr;
        #1;
        check("rd1_pre", rData1, exp_read(ra1));
        check("rd2_pre", rData2, exp_read(ra2));
        @(posedge clk);
        model_edge();
        #1;
        check("sp_report", reportSP, mem[SP_IDX]);
        check("sp_ovf", spOvf, flag);
        check("rd1_post", rData1, exp_read(ra1));
    endtask

    task automatic idle_inputs();
        wEn    = 1'b0;
        ovfClr = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rstn = 1'b0;
        #2;
        model_reset();
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        rstn    = 1'b0;
        rAddr1  = '0;
        rAddr2  = '0;
        wAddr   = '0;
        wData   = '0;
        wEn     = 1'b0;
        spLimit = '0;
        ovfClr  = 1'b0;
        model_reset();
        #12;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_rd1", rData1, 0);
        check("rst_rd2", rData2, 0);
        check("rst_sp", reportSP, 0);
        check("rst_ovf", spOvf, 0);

        // Single write then dual read of the same slot
        step(3'd0, 3'd0, 1'b1, 3'd3, 16'h1234, 16'h0000, 1'b0);
        step(3'd3, 3'd3, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0);
        check("r3_port1", rData1, 16'h1234);
        check("r3_port2", rData2, 16'h1234);
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 3) begin
                rAddr1 = 3'(i);
                rAddr2 = 3'(DEPTH - 1 - i);
                #1;
                check("other_slot", rData1, 0);
                check("other_slot2", rData2, mem[DEPTH-1-i]);
            end
        end

        // Same-cycle write/read of r2
        rAddr1 = 3'd2;
        rAddr2 = 3'd3;
        wEn    = 1'b1;
        wAddr  = 3'd2;
        wData  = 16'hAAAA;
        #1;
        check("fwd_r2", rData1, BYPASS ? 32'h0000_AAAA : 32'h0);
        step(3'd2, 3'd3, 1'b1, 3'd2, 16'hAAAA, 16'h0000, 1'b0);

        // SP init, then violation
        step(3'd7, 3'd2, 1'b1, 3'(SP_IDX), 16'h0200, 16'h0100, 1'b0);
        check("ovf_after_init", spOvf, 0);
        step(3'd7, 3'd2, 1'b1, 3'(SP_IDX), 16'h00FF, 16'h0100, 1'b0);
        check("ovf_tripped", spOvf, 1);
        check("sp_ff", reportSP, 16'h00FF);

        // Clear loses to a simultaneous violation, then clears alone
        step(3'd7, 3'd0, 1'b1, 3'(SP_IDX), 16'h0050, 16'h0100, 1'b1);
        check("clr_vs_viol", spOvf, 1);
        step(3'd7, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0100, 1'b1);
        check("clr_alone", spOvf, 0);

        // First SP write after reset is never range-checked; equality is legal
        pulse_reset();
        step(3'd7, 3'd1, 1'b1, 3'(SP_IDX), 16'h0000, 16'h0100, 1'b0);
        check("init_zero", spOvf, 0);
        step(3'd7, 3'd1, 1'b1, 3'(SP_IDX), 16'h0100, 16'h0100, 1'b0);
        check("equal_limit", spOvf, 0);
        step(3'd7, 3'd1, 1'b0, 3'd0, 16'h0000, 16'h0100, 1'b1);
        check("clr_in_armed", spOvf, 0);

        // Asynchronous reset while tripped with nonzero slots
        step(3'd7, 3'd5, 1'b1, 3'd5, 16'hBEEF, 16'h0100, 1'b0);
        step(3'd7, 3'd5, 1'b1, 3'(SP_IDX), 16'h0001, 16'h0100, 1'b0);
        check("pre_rst_ovf", spOvf, 1);
        idle_inputs();
        rAddr1 = 3'd7;
        rAddr2 = 3'd5;
        #2;
        rstn = 1'b0;
        #1;
        check("async_rd1", rData1, 0);
        check("async_rd2", rData2, 0);
        check("async_sp", reportSP, 0);
        check("async_ovf", spOvf, 0);
        model_reset();
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic, biased toward the SP slot
        for (int n = 0; n < 400; n++) begin
            logic [2:0]       wa;
            logic [WIDTH-1:0] wd;
            wa = ($urandom_range(0, 2) == 0) ? 3'(SP_IDX) : 3'($urandom_range(0, DEPTH - 1));
            wd = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(16'h00F0, 16'h0110))
                                              : WIDTH'($urandom);
            step(3'($urandom_range(0, DEPTH - 1)), 3'($urandom_range(0, DEPTH - 1)),
                 1'($urandom_range(0, 1)), wa, wd, 16'h0100,
                 ($urandom_range(0, 3) == 0));
            if (n == 200) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_2r.md
REG_FILE_2R -- requirements
Module: reg_file_2r

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of every slot.
REQ-002 SHALL have parameter DEPTH, default 8: slot count; power of two and at least 2.
REQ-003 SHALL have parameter SP_IDX, default DEPTH-1: slot treated as the stack pointer.
REQ-004 SHALL have port i_clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rstn  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port i_rAddr1  input  log2(DEPTH): read port 1 address.
REQ-007 SHALL have port o_rData1  output  WIDTH: read port 1 data.
REQ-008 SHALL have port i_rAddr2  input  log2(DEPTH): read port 2 address.
REQ-009 SHALL have port o_rData2  output  WIDTH: read port 2 data.
REQ-010 SHALL have port i_wData  input  WIDTH: write data.
REQ-011 SHALL have port i_wAddr  input  log2(DEPTH): write address.
REQ-012 SHALL have port i_wEn  input  1: write enable.
REQ-013 SHALL have port i_spLimit  input  WIDTH: lowest legal stack-pointer value, unsigned.
REQ-014 SHALL have port i_ovfClr  input  1: clear request for the overflow flag.
REQ-015 SHALL have port o_reportSP  output  WIDTH: current contents of slot SP_IDX.
REQ-016 SHALL have port o_spOvf  output  1: sticky stack-overflow flag.

Function
REQ-017 SHALL write i_wData into slot i_wAddr at the rising edge when i_wEn=1; all other slots hold.
REQ-018 SHALL make both reads combinational: o_rDataN = slot[i_rAddrN] with zero-cycle latency.
REQ-019 SHALL allow both read ports to select the same address or different addresses independently.
REQ-020 SHALL drive o_reportSP combinationally from the registered slot SP_IDX. It is never bypassed.
REQ-021 SHALL implement an overflow FSM with states IDLE, ARMED and TRIPPED. o_spOvf=1 only in TRIPPED.
REQ-022 IDLE -> ARMED on any write to SP_IDX. This first write is the SP initialisation and is not range-checked.
REQ-023 ARMED -> TRIPPED on a write to SP_IDX with i_wData < i_spLimit (unsigned compare). Otherwise it stays ARMED.
REQ-024 In TRIPPED, i_ovfClr=1 -> ARMED at the next edge. Without i_ovfClr it stays TRIPPED (sticky).
REQ-025 In TRIPPED, i_ovfClr=1 together with a violating SP write SHALL keep the FSM in TRIPPED (violation wins).
REQ-026 i_ovfClr in IDLE or ARMED SHALL have no effect.
REQ-027 A violating SP write SHALL still update the slot. The flag is advisory only.
REQ-028 i_wData == i_spLimit SHALL be legal, so the FSM does not trip.

Reset
REQ-029 i_rstn=0 SHALL asynchronously clear all slots to 0 and put the FSM in IDLE.
REQ-030 After reset, o_rData1, o_rData2 and o_reportSP SHALL read 0, and o_spOvf SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL abandon any same-cycle write and any pending trip.

Configuration
REQ-032 With macro REG_FILE_BYPASS_EN defined: if i_wEn=1 and i_rAddrN==i_wAddr, o_rDataN SHALL return i_wData in the same cycle (write-to-read forwarding), independently per port.
REQ-033 Without REG_FILE_BYPASS_EN: reads SHALL return the pre-write slot contents, and the new value is visible the cycle after the edge.

Structure
REQ-034 Package reg_file_pkg SHALL hold the FSM state enum (IDLE, ARMED, TRIPPED) and the default WIDTH and DEPTH constants.
REQ-035 The overflow FSM SHALL be sub-module sp_ovf_monitor, with inputs spWrEn, wData, spLimit, ovfClr, clk and rstn, and output ovf.
REQ-036 Slot storage SHALL use a parametrised array with a one-hot write decode generated from DEPTH.

Verification
REQ-037 Reset, then write 0x1234 to r3; read r3 on both ports -> 0x1234 on both one cycle later; all other slots read 0.
REQ-038 Write 0xAAAA to r2 with i_rAddr1=2 in the same cycle -> o_rData1=0xAAAA that cycle with REG_FILE_BYPASS_EN; 0x0000 without it.
REQ-039 Set i_spLimit=0x0100, write SP=0x0200, then SP=0x00FF -> o_spOvf=0 after the first write and 1 after the second; o_reportSP=0x00FF.
REQ-040 From TRIPPED, pulse i_ovfClr together with a write of SP=0x0050 -> o_spOvf stays 1; i_ovfClr alone next cycle -> o_spOvf=0.
REQ-041 From reset, first write SP=0x0000 with i_spLimit=0x0100 -> o_spOvf=0 (IDLE init); write SP=0x0100 -> still 0.
REQ-042 Deassert i_rstn between edges while TRIPPED with nonzero slots -> all outputs 0 immediately, with no clock edge required.
